// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : core_sequencer
// Brief    : Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for an RV64I core
// Revision : 1.0 - initial release
// ============================================================================
module core_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic        clk_i,
    input  logic        cntrst_i,
    input  logic        start_i,
    input  logic        halt_i,
    output logic        imem_req_o,
    input  logic        imem_ack_i,
    output logic        ir_ld_o,
    input  logic [6:0]  opcode_i,
    input  logic        RWR_EN_i,
    input  logic        JALRE_i,
    input  logic        UJE_i,
    input  logic        BE_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    input  logic        dmem_ack_i,
    output logic        rf_we_o,
    output logic        pc_ld_o,
    output logic [1:0]  pc_sel_o,
    output logic        retire_o,
    output logic [31:0] instret_o,
    output logic [2:0]  state_o,
    output logic        busy_o,
    output logic        err_o
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_FETCH  = 3'd1;
    localparam logic [2:0] c_DECODE = 3'd2;
    localparam logic [2:0] c_EXEC   = 3'd3;
    localparam logic [2:0] c_MEM    = 3'd4;
    localparam logic [2:0] c_WB     = 3'd5;
    localparam logic [2:0] c_ERR    = 3'd6;

    localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
    localparam logic [6:0] c_OP_LOAD   = 7'h03;
    localparam logic [6:0] c_OP_STORE  = 7'h23;
    localparam logic [6:0] c_OP_BRANCH = 7'h63;

    logic [2:0]       state_q,   state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [6:0]       opcode_q,  opcode_d;
    logic [31:0]      instret_q, instret_d;

    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            7'h03, 7'h13, 7'h1B, 7'h17, 7'h23, 7'h33,
            7'h37, 7'h3B, 7'h63, 7'h67, 7'h6F: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        opcode_d   = opcode_q;
        instret_d  = instret_q;
        case (state_q)
            c_IDLE: begin
                if (start_i) begin
                    state_d    = c_FETCH;
                    wait_cnt_d = '0;
                end
            end
            c_FETCH: begin
                // An ack in the final permitted cycle wins over the timeout
                if (imem_ack_i)                   state_d = c_DECODE;
                else if (wait_cnt_q == c_TIMEOUT) state_d = c_ERR;
                else                              wait_cnt_d = wait_cnt_q + 1'b1;
            end
            c_DECODE: begin
                opcode_d = opcode_i;
                state_d  = is_legal(opcode_i) ? c_EXEC : c_ERR;
            end
            c_EXEC: begin
                if (opcode_q == c_OP_LOAD || opcode_q == c_OP_STORE) begin
                    state_d    = c_MEM;
                    wait_cnt_d = '0;
                end else begin
                    state_d = c_WB;
                end
            end
            c_MEM: begin
                if (dmem_ack_i)                   state_d = c_WB;
                else if (wait_cnt_q == c_TIMEOUT) state_d = c_ERR;
                else                              wait_cnt_d = wait_cnt_q + 1'b1;
            end
            c_WB: begin
                instret_d = instret_q + 32'd1;
                if (halt_i) begin
                    state_d = c_IDLE;
                end else begin
                    state_d    = c_FETCH;
                    wait_cnt_d = '0;
                end
            end
            c_ERR:   state_d = c_ERR;
            default: state_d = c_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (cntrst_i) begin
            state_q    <= c_IDLE;
            wait_cnt_q <= '0;
            opcode_q   <= '0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            opcode_q   <= opcode_d;
            instret_q  <= instret_d;
        end
    end

    // Decoder enables are only looked at in WB so each acts once per instruction
    always_comb begin
        imem_req_o = (state_q == c_FETCH);
        ir_ld_o    = (state_q == c_FETCH) && imem_ack_i;
        dmem_req_o = (state_q == c_MEM);
        dmem_we_o  = (state_q == c_MEM) && (opcode_q == c_OP_STORE);
        pc_ld_o    = (state_q == c_WB);
        retire_o   = (state_q == c_WB);
        rf_we_o    = (state_q == c_WB) && RWR_EN_i &&
                     (opcode_q != c_OP_STORE) && (opcode_q != c_OP_BRANCH);
        pc_sel_o   = 2'b00;
        if (state_q == c_WB) begin
            if (JALRE_i)    pc_sel_o = 2'b10;
            else if (UJE_i) pc_sel_o = 2'b11;
            else if (BE_i)  pc_sel_o = 2'b01;
        end
        busy_o     = (state_q >= c_FETCH) && (state_q <= c_WB);
        err_o      = (state_q == c_ERR);
        state_o    = state_q;
        instret_o  = instret_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_core_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_sequencer
// Brief    : Self-checking bench for core_sequencer (vector table + scoreboard)
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_sequencer;

    logic        clk_i = 1'b0;
    logic        cntrst_i = 1'b1;
    logic        start_i = 1'b0, halt_i = 1'b0;
    logic        imem_req_o, imem_ack_i = 1'b0, ir_ld_o;
    logic [6:0]  opcode_i = 7'h00;
    logic        RWR_EN_i = 1'b0, JALRE_i = 1'b0, UJE_i = 1'b0, BE_i = 1'b0;
    logic        dmem_req_o, dmem_we_o, dmem_ack_i = 1'b0;
    logic        rf_we_o, pc_ld_o, retire_o, busy_o, err_o;
    logic [1:0]  pc_sel_o;
    logic [31:0] instret_o;
    logic [2:0]  state_o;

    core_sequencer #(.TIMEOUT(15), .CNT_W(8)) dut (
        .clk_i(clk_i), .cntrst_i(cntrst_i), .start_i(start_i), .halt_i(halt_i),
        .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i), .ir_ld_o(ir_ld_o),
        .opcode_i(opcode_i), .RWR_EN_i(RWR_EN_i), .JALRE_i(JALRE_i),
        .UJE_i(UJE_i), .BE_i(BE_i), .dmem_req_o(dmem_req_o),
        .dmem_we_o(dmem_we_o), .dmem_ack_i(dmem_ack_i), .rf_we_o(rf_we_o),
        .pc_ld_o(pc_ld_o), .pc_sel_o(pc_sel_o), .retire_o(retire_o),
        .instret_o(instret_o), .state_o(state_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [6:0] op;
        bit         rwr, jalre, uje, be, halt;
        int         imem_dly, dmem_dly;
        bit         exp_mem, exp_we, exp_rf;
        logic [1:0] exp_sel;
    } vec_t;

    typedef struct {
        bit          rf;
        logic [1:0]  sel;
        logic [31:0] instret;
    } sb_t;

    vec_t        vecs[8];
    sb_t         sb_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_instret = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Scoreboard: every retire pulse must match the oldest pending expectation
    always @(negedge clk_i) begin
        if (retire_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_retire: got retire with empty queue (t=%0t)", $time);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_rf_we", {31'd0, rf_we_o}, {31'd0, e.rf});
                chk("sb_pc_sel", {30'd0, pc_sel_o}, {30'd0, e.sel});
                chk("sb_instret_next", instret_o + 32'd1, e.instret);
            end
        end
    end

    task automatic start_from_idle();
        chk("idle_state", {29'd0, state_o}, 32'd0);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    // Entered with the DUT in FETCH; leaves it one cycle after WB
    task automatic run_instr(input vec_t v);
        sb_t e;
        exp_instret = exp_instret + 32'd1;
        e.rf = v.exp_rf; e.sel = v.exp_sel; e.instret = exp_instret;
        sb_q.push_back(e);
        for (int k = 0; k < v.imem_dly; k++) begin
            chk("fetch_wait_state", {29'd0, state_o}, 32'd1);
            chk("fetch_wait_req", {31'd0, imem_req_o & ~ir_ld_o}, 32'd1);
            tick();
        end
        imem_ack_i = 1'b1;
        #0;
        chk("fetch_ir_ld", {31'd0, ir_ld_o}, 32'd1);
        tick();
        imem_ack_i = 1'b0;
        opcode_i = v.op;
        chk("decode_state", {29'd0, state_o}, 32'd2);
        tick();
        chk("exec_state", {29'd0, state_o}, 32'd3);
        tick();
        if (v.exp_mem) begin
            for (int k = 0; k <= v.dmem_dly; k++) begin
                if (k == v.dmem_dly) dmem_ack_i = 1'b1;
                chk("mem_state", {29'd0, state_o}, 32'd4);
                chk("mem_req_we", {30'd0, dmem_req_o, dmem_we_o}, {30'd0, 1'b1, v.exp_we});
                tick();
            end
            dmem_ack_i = 1'b0;
        end
        RWR_EN_i = v.rwr; JALRE_i = v.jalre; UJE_i = v.uje; BE_i = v.be; halt_i = v.halt;
        #1;
        chk("wb_state", {29'd0, state_o}, 32'd5);
        chk("wb_strobes", {29'd0, pc_ld_o, retire_o, rf_we_o}, {29'd0, 1'b1, 1'b1, v.exp_rf});
        chk("wb_pc_sel", {30'd0, pc_sel_o}, {30'd0, v.exp_sel});
        tick();
        RWR_EN_i = 1'b0; JALRE_i = 1'b0; UJE_i = 1'b0; BE_i = 1'b0; halt_i = 1'b0;
        chk("wb_next_state", {29'd0, state_o}, v.halt ? 32'd0 : 32'd1);
        chk("instret", instret_o, exp_instret);
    endtask

    task automatic do_reset();
        cntrst_i = 1'b1;
        tick();
        tick();
        cntrst_i = 1'b0;
        exp_instret = 32'd0;
        sb_q.delete();
    endtask

    initial begin
        //          op     rwr jr  uj  be  hlt imd dmd mem we  rf  sel
        vecs[0] = '{7'h13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2'b00};
        vecs[1] = '{7'h03, 1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 2'b00};
        vecs[2] = '{7'h23, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2'b00};
        vecs[3] = '{7'h67, 1, 1, 0, 1, 0, 2, 0, 0, 0, 1, 2'b10};
        vecs[4] = '{7'h6F, 1, 0, 1, 1, 0, 0, 0, 0, 0, 1, 2'b11};
        vecs[5] = '{7'h33, 0, 0, 0, 0, 0, 15, 0, 0, 0, 0, 2'b00};
        vecs[6] = '{7'h37, 1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 2'b00};
        vecs[7] = '{7'h63, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2'b01};

        do_reset();
        chk("rst_state_busy_err", {27'd0, state_o, busy_o, err_o}, 32'd0);
        chk("rst_instret", instret_o, 32'd0);
        chk("rst_strobes", {23'd0, imem_req_o, ir_ld_o, dmem_req_o, dmem_we_o,
                            rf_we_o, pc_ld_o, retire_o, pc_sel_o}, 32'd0);

        start_from_idle();
        chk("busy_in_fetch", {31'd0, busy_o}, 32'd1);
        for (int i = 0; i < 8; i++) run_instr(vecs[i]);
        chk("halt_busy", {31'd0, busy_o}, 32'd0);

        // Reset during the second MEM wait cycle of a load
        start_from_idle();
        imem_ack_i = 1'b1; tick(); imem_ack_i = 1'b0;
        opcode_i = 7'h03; tick(); tick(); tick();
        chk("mid_mem_req", {29'd0, state_o}, 32'd4);
        cntrst_i = 1'b1;
        tick();
        cntrst_i = 1'b0;
        exp_instret = 32'd0;
        chk("mid_mem_rst_state", {29'd0, state_o}, 32'd0);
        chk("mid_mem_rst_outs", {30'd0, dmem_req_o, busy_o}, 32'd0);
        chk("mid_mem_rst_instret", instret_o, 32'd0);

        // instret wrap from a forced all-ones value
        start_from_idle();
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_instret = 32'hFFFF_FFFF;
        vecs[0].halt = 1;
        run_instr(vecs[0]);
        chk("instret_wrap", instret_o, 32'd0);

        // FETCH timeout: 16 unacknowledged cycles, then sticky ERR
        start_from_idle();
        for (int k = 0; k < 16; k++) begin
            chk("to_fetch_state", {29'd0, state_o}, 32'd1);
            tick();
        end
        chk("to_err_state", {29'd0, state_o}, 32'd6);
        chk("to_err_flags", {29'd0, err_o, busy_o, imem_req_o}, 32'd4);
        start_i = 1'b1;
        imem_ack_i = 1'b1;
        tick(); tick(); tick();
        start_i = 1'b0;
        imem_ack_i = 1'b0;
        chk("err_sticky", {28'd0, state_o, err_o}, {28'd0, 3'd6, 1'b1});

        // Illegal opcode traps straight out of DECODE
        do_reset();
        chk("rst_clears_err", {31'd0, err_o}, 32'd0);
        start_from_idle();
        imem_ack_i = 1'b1; tick(); imem_ack_i = 1'b0;
        opcode_i = 7'h7F;
        chk("illegal_decode", {29'd0, state_o}, 32'd2);
        tick();
        chk("illegal_err", {28'd0, state_o, err_o}, {28'd0, 3'd6, 1'b1});
        chk("illegal_no_retire", {31'd0, retire_o}, 32'd0);

        chk("sb_drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
